// File: rtl/fir_out_reader.sv
// fir_out_reader
// Pops filtered FIR results from the output FIFO into a 2-entry prefetch
// buffer and presents them as a valid/ready stream toward the bus read path.
// Each word is converted on the way out: full-precision sign extension
// (mode 0) or round-half-up plus saturation back to BIT_PREC bits (mode 1).
//
// Stream handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high. out_valid depends only on registered state; once
// raised it stays high until a transfer, and the buffered head entry does not
// move while stalled. out_ready may be asserted at any time; asserting it with
// out_valid low is a consumer error and sets the sticky err_underflow flag.
module fir_out_reader #(
  parameter int DWIDTH   = 32,
  parameter int OUT_SIZE = 21,
  parameter int BIT_PREC = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // output FIFO read port (one-cycle read latency)
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [OUT_SIZE-1:0] fifo_rdata,
  // conversion select
  input  logic                mode,
  // outgoing stream
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   out_data,
  // status
  input  logic                clr,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                err_underflow
);

  // Rounding constant and saturation bounds, all at OUT_SIZE+1 bits so the
  // rounding add cannot overflow.
  localparam logic signed [OUT_SIZE:0] RND_HALF =
    {{(OUT_SIZE + 1 - BIT_PREC){1'b0}}, 1'b1, {(BIT_PREC - 1){1'b0}}};
  localparam logic signed [OUT_SIZE:0] SAT_MAX =
    {{(OUT_SIZE + 2 - BIT_PREC){1'b0}}, {(BIT_PREC - 1){1'b1}}};
  localparam logic signed [OUT_SIZE:0] SAT_MIN = ~SAT_MAX;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [OUT_SIZE-1:0] mem_q [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          occ_q, occ_d;
  logic                inflight_q, inflight_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                err_q, err_d;

  // ---------------------------------------------------------------------------
  // Handshake and prefetch control
  // ---------------------------------------------------------------------------
  logic       pop_now;
  logic [2:0] level_after_pop;

  assign out_valid = (occ_q != 2'd0);
  assign pop_now   = out_valid && out_ready;

  // Words held or on their way (buffer + inflight) once this cycle's transfer
  // has left. A pop is only issued if that leaves room for the returning word.
  assign level_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_now};
  assign fifo_rd_en      = !fifo_empty && (level_after_pop < 3'd2);

  // Next-state for pointers, occupancy, counter and error flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = level_after_pop[1:0];
    inflight_d = fifo_rd_en;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;

    // A word popped last cycle lands in the slot at wr_ptr this edge.
    if (inflight_q) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop_now) begin
      rd_ptr_d   = ~rd_ptr_q;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    if (out_ready && !out_valid) begin
      err_d = 1'b1;
    end

    // Clear has priority over both counting and error capture.
    if (clr) begin
      word_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  // Registered control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  // Buffer storage: capture returning FIFO data; cleared on reset so the idle
  // output converts to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (inflight_q) begin
      mem_q[wr_ptr_q] <= fifo_rdata;
    end
  end

  assign word_cnt      = word_cnt_q;
  assign err_underflow = err_q;

  // ---------------------------------------------------------------------------
  // Output conversion (applied to the head entry at output time, so a mode
  // change also affects a word that is already buffered)
  // ---------------------------------------------------------------------------
  logic [OUT_SIZE-1:0]        head;
  logic signed [OUT_SIZE:0]   head_wide;
  logic signed [OUT_SIZE:0]   rnd_sum;
  logic signed [OUT_SIZE:0]   rnd_shift;
  logic [BIT_PREC-1:0]        sat_val;
  logic [DWIDTH-1:0]          full_ext;
  logic [DWIDTH-1:0]          prec_ext;

  assign head      = mem_q[rd_ptr_q];
  assign head_wide = $signed({head[OUT_SIZE-1], head});
  assign rnd_sum   = head_wide + RND_HALF;
  assign rnd_shift = rnd_sum >>> BIT_PREC;
  assign full_ext  = {{(DWIDTH - OUT_SIZE){head[OUT_SIZE-1]}}, head};

  // Clip the rounded value into the signed BIT_PREC range.
  always_comb begin
    sat_val = rnd_shift[BIT_PREC-1:0];
    if (rnd_shift > SAT_MAX) begin
      sat_val = {1'b0, {(BIT_PREC - 1){1'b1}}};
    end else if (rnd_shift < SAT_MIN) begin
      sat_val = {1'b1, {(BIT_PREC - 1){1'b0}}};
    end
  end

  assign prec_ext = {{(DWIDTH - BIT_PREC){sat_val[BIT_PREC-1]}}, sat_val};
  assign out_data = mode ? prec_ext : full_ext;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= 2'd2);

  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));

  a_valid_held : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> out_valid);

endmodule

// File: tb/tb_fir_out_reader.sv
// Bench for fir_out_reader: a queue-free FIFO model feeds the DUT, a
// collector records every completed transfer, and each test compares the
// collected words against values computed from the conversion rules.
module tb_fir_out_reader;

  localparam int DW = 32;
  localparam int OS = 21;
  localparam int CW = 16;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT signals
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [OS-1:0] fifo_rdata;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          clr;
  logic [CW-1:0] word_cnt;
  logic          err_underflow;

  fir_out_reader #(.DWIDTH(DW), .OUT_SIZE(OS), .BIT_PREC(8), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rdata    (fifo_rdata),
    .mode          (mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .clr           (clr),
    .word_cnt      (word_cnt),
    .err_underflow (err_underflow)
  );

  // FIFO model: wr_idx advanced by the driver, rd_idx by the read port.
  logic [OS-1:0] fifo_mem [64];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          endless = 1'b0;

  assign fifo_empty = endless ? 1'b0 : (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_en) begin
      if (endless) begin
        fifo_rdata <= OS'($urandom);
      end else if (rd_idx != wr_idx) begin
        fifo_rdata <= fifo_mem[rd_idx % 64];
        rd_idx     <= rd_idx + 1;
      end
    end
  end

  // scoreboard
  int              total = 0;
  int              bad   = 0;
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   obs_q[$];
  int              stab_viol, rden_viol, empty_viol;
  int              first_rden, first_valid;

  // Reference conversion from the arithmetic rules.
  function automatic logic [DW-1:0] model_convert(input logic [OS-1:0] raw, input logic m);
    longint v, n, q;
    v = longint'(raw);
    if (raw[OS-1]) v = v - (longint'(1) << OS);
    if (!m) return DW'(v);
    n = v + 128;
    if (n >= 0) q = n / 256;
    else        q = -((-n + 255) / 256);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return DW'(q);
  endfunction

  // driver tasks
  task automatic push_word(input logic [OS-1:0] w);
    fifo_mem[wr_idx % 64] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    endless   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the stream with a ready pattern (0 always, 1 toggle, 2 random) until
  // 'want' transfers are seen or the cycle budget runs out. Called at a negedge.
  task automatic collect(input int want, input int rmode, input int max_cycles);
    int   issued, delivered;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    obs_q.delete();
    stab_viol = 0; rden_viol = 0; empty_viol = 0;
    first_rden = -1; first_valid = -1;
    issued = 0; delivered = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < max_cycles && obs_q.size() < want; c++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (fifo_rd_en && first_rden < 0) first_rden = c;
      if (out_valid && first_valid < 0) first_valid = c;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_viol++;
      if (fifo_rd_en && fifo_empty) empty_viol++;
      if (fifo_rd_en && (issued - delivered - int'(out_valid && out_ready)) >= 2) rden_viol++;
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        delivered++;
      end
      if (fifo_rd_en) issued++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; clr = 1'b0; mode = 1'b0; endless = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", out_data); end
    total++; if (word_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", word_cnt); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_underflow); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL idle_c%0d rd_en=%b valid=%b exp=0/0", c, fifo_rd_en, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mode0();
    logic [OS-1:0] w [2];
    logic [DW-1:0] lit [2];
    logic [DW-1:0] got;
    w = '{21'h1FFFFB, 21'h000123};
    lit = '{32'hFFFFFFFB, 32'h00000123};
    apply_reset();
    mode = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      push_word(w[i]);
      exp_q.push_back(model_convert(w[i], 1'b0));
    end
    collect(2, 0, 50);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL m0_count got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL m0_data%0d got=%h exp=%h", i, got, exp_q[i]); end
      total++; if (got !== lit[i]) begin bad++; $display("FAIL m0_lit%0d got=%h exp=%h", i, got, lit[i]); end
    end
    total++;
    if (first_valid - first_rden != 2) begin
      bad++; $display("FAIL m0_latency got=%0d exp=2", first_valid - first_rden);
    end
  endtask

  task automatic test_mode1_round();
    logic [OS-1:0] w [3];
    logic [DW-1:0] lit [3];
    logic [DW-1:0] got;
    w = '{21'd896, 21'h1FFE80, 21'd127};
    lit = '{32'h00000004, 32'hFFFFFFFF, 32'h00000000};
    apply_reset();
    mode = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      push_word(w[i]);
      exp_q.push_back(model_convert(w[i], 1'b1));
    end
    collect(3, 0, 50);
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL rnd_data%0d got=%h exp=%h", i, got, exp_q[i]); end
      total++; if (got !== lit[i]) begin bad++; $display("FAIL rnd_lit%0d got=%h exp=%h", i, got, lit[i]); end
    end
  endtask

  task automatic test_mode1_sat();
    logic [OS-1:0] w [2];
    logic [DW-1:0] lit [2];
    logic [DW-1:0] got;
    w = '{21'h07FFFF, 21'h100000};
    lit = '{32'h0000007F, 32'hFFFFFF80};
    apply_reset();
    mode = 1'b1;
    for (int i = 0; i < 2; i++) push_word(w[i]);
    collect(2, 0, 50);
    for (int i = 0; i < 2; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++; if (got !== lit[i]) begin bad++; $display("FAIL sat%0d got=%h exp=%h", i, got, lit[i]); end
      total++; if (got !== model_convert(w[i], 1'b1)) begin bad++; $display("FAIL sat_model%0d got=%h", i, got); end
    end
  endtask

  task automatic test_mode_switch();
    logic [OS-1:0] w;
    w = 21'h1FF3C0;
    apply_reset();
    mode = 1'b0;
    push_word(w);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sw_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== model_convert(w, 1'b0)) begin bad++; $display("FAIL sw_m0 got=%h exp=%h", out_data, model_convert(w, 1'b0)); end
    mode = 1'b1;
    #1;
    total++; if (out_data !== 32'hFFFFFFF4) begin bad++; $display("FAIL sw_m1 got=%h exp=fffffff4", out_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got;
    apply_reset();
    mode = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      logic [OS-1:0] w;
      w = OS'($urandom);
      push_word(w);
      exp_q.push_back(model_convert(w, 1'b0));
    end
    collect(10, 1, 200);
    total++; if (obs_q.size() != 10) begin bad++; $display("FAIL bp_count got=%0d exp=10", obs_q.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL bp_data%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
    total++; if (rden_viol != 0) begin bad++; $display("FAIL bp_rd_en_full got=%0d exp=0", rden_viol); end
    total++; if (empty_viol != 0) begin bad++; $display("FAIL bp_rd_en_empty got=%0d exp=0", empty_viol); end
    #1;
    total++; if (word_cnt !== 16'd10) begin bad++; $display("FAIL bp_cnt got=%0d exp=10", word_cnt); end
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] got;
    logic          m;
    apply_reset();
    m = 1'($urandom_range(0, 1));
    mode = m;
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      logic [OS-1:0] w;
      w = OS'($urandom);
      push_word(w);
      exp_q.push_back(model_convert(w, m));
    end
    collect(24, 2, 400);
    total++; if (obs_q.size() != 24) begin bad++; $display("FAIL rs_count got=%0d exp=24", obs_q.size()); end
    for (int i = 0; i < 24; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL rs_data%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    total++; if (stab_viol + rden_viol + empty_viol != 0) begin
      bad++; $display("FAIL rs_protocol got=%0d/%0d/%0d exp=0/0/0", stab_viol, rden_viol, empty_viol);
    end
  endtask

  task automatic test_underflow_clear();
    apply_reset();
    mode = 1'b0;
    for (int i = 0; i < 3; i++) push_word(OS'($urandom));
    collect(3, 0, 50);
    #1;
    total++; if (word_cnt !== 16'd3) begin bad++; $display("FAIL uf_cnt3 got=%0d exp=3", word_cnt); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b0 || word_cnt !== '0) begin
      bad++; $display("FAIL uf_clr1 err=%b cnt=%0d exp=0/0", err_underflow, word_cnt);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
    @(negedge clk);
    clr = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uf_clr_wins got=%b exp=0", err_underflow); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    mode = 1'b0;
    endless = 1'b1;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      #1;
      if (out_valid) n++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    endless = 1'b0;
    #1;
    total++; if (n != 65535) begin bad++; $display("FAIL wrap_budget got=%0d exp=65535", n); end
    total++; if (word_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", word_cnt); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++; if (word_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_post got=%h exp=0000", word_cnt); end
    @(negedge clk);
  endtask

  // main sequence
  initial begin
    rst_n = 1'b0; out_ready = 1'b0; clr = 1'b0; mode = 1'b0;
    fifo_rdata = '0;
    test_reset();
    test_mode0();
    test_mode1_round();
    test_mode1_sat();
    test_mode_switch();
    test_backpressure();
    test_random_stream();
    test_underflow_clear();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
